// File: rtl/axi4_lite_arb_pkg.sv
// Shared definitions for the AXI4-Lite master arbiter.
// Holds the arbiter FSM state encoding and the AXI4-Lite response codes.
package axi4_lite_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle (no clock/reset inside; both sides share the system clock).
// master modport : drives AW/W/AR valid+payload, B/R ready.
// slave modport  : drives AW/W/AR ready, B/R valid+payload.
interface axi4_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4_lite_mst_arbiter_rr.sv
// rr_arbiter: purely combinational round-robin selector.
// req_i        : request vector, one bit per requester.
// last_grant_i : index granted last; search starts at last_grant_i+1.
// gnt_idx_o    : index of the selected requester (valid when gnt_valid_o).
// gnt_valid_o  : at least one request is present.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);

  // cand_idx[k] is the requester k+1 positions after the last grant.
  logic [N_REQ-1:0][IDX_W-1:0] cand_idx;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum = {1'b0, last_grant_i} + (IDX_W+1)'(gi + 1);
      assign cand_idx[gi] = (sum >= (IDX_W+1)'(N_REQ)) ?
                            IDX_W'(sum - (IDX_W+1)'(N_REQ)) : sum[IDX_W-1:0];
    end
  endgenerate

  // Scan farthest-first so the nearest active candidate is the final winner.
  always_comb begin
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_i[cand_idx[k]]) begin
        gnt_idx_o   = cand_idx[k];
        gnt_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_mst_arbiter.sv
// axi4_lite_mst_arbiter: funnels N_REQ simple command ports onto one
// AXI4-Lite master, one transaction in flight, round-robin grant.
// i_clk / i_sync_rst_n : clock, synchronous active-low reset.
// i_req_* / o_req_ready: per-requester command handshake (ready only in IDLE).
// o_rsp_valid          : one-cycle completion pulse for the granted requester.
// o_rsp_rdata/o_rsp_resp: shared read data / response code, held until next completion.
// if_m_axi4_lite       : shared AXI4-Lite master port.
module axi4_lite_mst_arbiter
  import axi4_lite_arb_pkg::*;
#(
  parameter int N_REQ                    = 2,
  parameter int AXI4_LITE_ADDR_BIT_WIDTH = 32,
  parameter int AXI4_LITE_DATA_BIT_WIDTH = 32
) (
  input  logic                                               i_clk,
  input  logic                                               i_sync_rst_n,
  input  logic [N_REQ-1:0]                                   i_req_valid,
  output logic [N_REQ-1:0]                                   o_req_ready,
  input  logic [N_REQ-1:0]                                   i_req_we,
  input  logic [N_REQ-1:0][AXI4_LITE_ADDR_BIT_WIDTH-1:0]     i_req_addr,
  input  logic [N_REQ-1:0][AXI4_LITE_DATA_BIT_WIDTH-1:0]     i_req_wdata,
  input  logic [N_REQ-1:0][AXI4_LITE_DATA_BIT_WIDTH/8-1:0]   i_req_wstrb,
  output logic [N_REQ-1:0]                                   o_rsp_valid,
  output logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]                o_rsp_rdata,
  output logic [1:0]                                         o_rsp_resp,
  axi4_lite_if.master                                        if_m_axi4_lite
);

  localparam int ADDR_W = AXI4_LITE_ADDR_BIT_WIDTH;
  localparam int DATA_W = AXI4_LITE_DATA_BIT_WIDTH;
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(N_REQ);

  arb_state_t          state_q;
  logic [IDX_W-1:0]    last_grant_q;
  logic [IDX_W-1:0]    gnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                arvalid_q;
  logic [N_REQ-1:0]    rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [1:0]          rsp_resp_q;

  logic [IDX_W-1:0]    gnt_idx;
  logic                gnt_valid;
  logic                accept_d;
  logic [N_REQ-1:0]    gnt_onehot_d;
  logic                aw_hs_d;
  logic                w_hs_d;
  logic                aw_done_d;
  logic                w_done_d;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i        (i_req_valid),
    .last_grant_i (last_grant_q),
    .gnt_idx_o    (gnt_idx),
    .gnt_valid_o  (gnt_valid)
  );

  // Reset gates acceptance so nothing is taken in a reset cycle.
  assign accept_d = i_sync_rst_n && (state_q == IDLE) && gnt_valid;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign o_req_ready[gi]  = accept_d && (gnt_idx == IDX_W'(gi));
      assign gnt_onehot_d[gi] = (gnt_q == IDX_W'(gi));
    end
  endgenerate

  // AW and W retire independently; a channel already retired counts as done.
  assign aw_hs_d   = awvalid_q && if_m_axi4_lite.awready;
  assign w_hs_d    = wvalid_q && if_m_axi4_lite.wready;
  assign aw_done_d = aw_hs_d || !awvalid_q;
  assign w_done_d  = w_hs_d || !wvalid_q;

  always_ff @(posedge i_clk) begin
    if (!i_sync_rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(N_REQ - 1);
      gnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_resp_q   <= RESP_OKAY;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            gnt_q        <= gnt_idx;
            last_grant_q <= gnt_idx;
            addr_q       <= i_req_addr[gnt_idx];
            wdata_q      <= i_req_wdata[gnt_idx];
            wstrb_q      <= i_req_wstrb[gnt_idx];
            if (i_req_we[gnt_idx]) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_ADDR;
            end
          end
        end
        WR: begin
          if (aw_hs_d) awvalid_q <= 1'b0;
          if (w_hs_d)  wvalid_q  <= 1'b0;
          if (aw_done_d && w_done_d) state_q <= WR_RESP;
        end
        WR_RESP: begin
          if (if_m_axi4_lite.bvalid) begin
            rsp_resp_q  <= if_m_axi4_lite.bresp;
            rsp_valid_q <= gnt_onehot_d;
            state_q     <= RSP;
          end
        end
        RD_ADDR: begin
          if (if_m_axi4_lite.arready) begin
            arvalid_q <= 1'b0;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (if_m_axi4_lite.rvalid) begin
            rsp_rdata_q <= if_m_axi4_lite.rdata;
            rsp_resp_q  <= if_m_axi4_lite.rresp;
            rsp_valid_q <= gnt_onehot_d;
            state_q     <= RSP;
          end
        end
        RSP: begin
          rsp_valid_q <= '0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_m_axi4_lite.awvalid = awvalid_q;
  assign if_m_axi4_lite.awaddr  = addr_q;
  assign if_m_axi4_lite.awprot  = 3'b000;
  assign if_m_axi4_lite.wvalid  = wvalid_q;
  assign if_m_axi4_lite.wdata   = wdata_q;
  assign if_m_axi4_lite.wstrb   = wstrb_q;
  assign if_m_axi4_lite.bready  = (state_q == WR_RESP);
  assign if_m_axi4_lite.arvalid = arvalid_q;
  assign if_m_axi4_lite.araddr  = addr_q;
  assign if_m_axi4_lite.arprot  = 3'b000;
  assign if_m_axi4_lite.rready  = (state_q == RD_DATA);

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axi4_lite_mst_arbiter.sv
// Directed bench for axi4_lite_mst_arbiter with a small behavioural AXI4-Lite
// slave (16-word memory at 0x00..0x3F, SLVERR elsewhere, programmable W stall).
module tb_axi4_lite_mst_arbiter;
  import axi4_lite_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_we;
  logic [1:0][31:0]  req_addr;
  logic [1:0][31:0]  req_wdata;
  logic [1:0][3:0]   req_wstrb;
  logic [1:0]        rsp_valid;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_resp;

  axi4_lite_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  axi4_lite_mst_arbiter #(
    .N_REQ                    (2),
    .AXI4_LITE_ADDR_BIT_WIDTH (32),
    .AXI4_LITE_DATA_BIT_WIDTH (32)
  ) dut (
    .i_clk          (clk),
    .i_sync_rst_n   (rst_n),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_we       (req_we),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .i_req_wstrb    (req_wstrb),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_rdata    (rsp_rdata),
    .o_rsp_resp     (rsp_resp),
    .if_m_axi4_lite (axi.master)
  );

  // ---------------- behavioural slave ----------------
  logic [31:0] mem [16];
  logic        aw_got, w_got;
  logic [31:0] aw_a, w_d, a_t, d_t;
  logic [3:0]  w_s, s_t;
  int          w_cnt;
  int          w_delay = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      axi.awready <= 1'b0; axi.wready <= 1'b0; axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
      axi.arready <= 1'b0; axi.rvalid <= 1'b0; axi.rdata <= '0;    axi.rresp <= 2'b00;
      aw_got <= 1'b0; w_got <= 1'b0; w_cnt <= 0;
    end else begin
      axi.awready <= axi.awvalid && !axi.awready && !aw_got;
      if (axi.awvalid && axi.awready) begin aw_got <= 1'b1; aw_a <= axi.awaddr; end
      if (axi.wvalid && !axi.wready && !w_got) begin
        if (w_cnt >= w_delay) axi.wready <= 1'b1;
        else w_cnt <= w_cnt + 1;
      end else axi.wready <= 1'b0;
      if (axi.wvalid && axi.wready) begin
        w_got <= 1'b1; w_d <= axi.wdata; w_s <= axi.wstrb; w_cnt <= 0;
      end
      if (axi.bvalid) begin
        if (axi.bready) axi.bvalid <= 1'b0;
      end else if ((aw_got || (axi.awvalid && axi.awready)) &&
                   (w_got || (axi.wvalid && axi.wready))) begin
        a_t = aw_got ? aw_a : axi.awaddr;
        d_t = w_got ? w_d : axi.wdata;
        s_t = w_got ? w_s : axi.wstrb;
        if (a_t < 32'd64) begin
          for (int b = 0; b < 4; b++) if (s_t[b]) mem[a_t[5:2]][8*b +: 8] <= d_t[8*b +: 8];
          axi.bresp <= RESP_OKAY;
        end else axi.bresp <= RESP_SLVERR;
        axi.bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end
      axi.arready <= axi.arvalid && !axi.arready;
      if (axi.rvalid) begin
        if (axi.rready) axi.rvalid <= 1'b0;
      end else if (axi.arvalid && axi.arready) begin
        axi.rvalid <= 1'b1;
        if (axi.araddr < 32'd64) begin axi.rdata <= mem[axi.araddr[5:2]]; axi.rresp <= RESP_OKAY; end
        else begin axi.rdata <= '0; axi.rresp <= RESP_SLVERR; end
      end
    end
  end

  // ---------------- bookkeeping ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_lat;
  } cmd_t;

  cmd_t cq [2][$];
  cmd_t pq [2][$];
  int   pc [2][$];
  int   glog[$];
  int   gcyc[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  int   rsp_cnt = 0;
  logic [31:0] last_rd_exp = '0;
  logic [1:0]  prev_rsp = '0;
  logic prev_aw_stall = 1'b0, prev_w_stall = 1'b0, prev_ar_stall = 1'b0;
  logic rst_arm = 1'b0, rst_hit = 1'b0;
  int   split_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sample();
    cmd_t c;
    int   a;
    for (int r = 0; r < 2; r++) begin
      if (req_valid[r] && req_ready[r]) begin
        pq[r].push_back(cq[r][0]);
        pc[r].push_back(cyc);
        glog.push_back(r);
        gcyc.push_back(cyc);
        void'(cq[r].pop_front());
      end
    end
    if (rsp_valid != 2'b00) begin
      rsp_cnt++;
      check_val("rsp_onehot", 64'($countones(rsp_valid)), 64'd1);
      check_val("rsp_single_cycle", 64'(prev_rsp), 64'd0);
      for (int r = 0; r < 2; r++) begin
        if (rsp_valid[r]) begin
          if (pq[r].size() == 0) begin
            check_val("rsp_unexpected_req", 64'(r), 64'hFF);
          end else begin
            c = pq[r].pop_front();
            a = pc[r].pop_front();
            check_val(c.we ? "wr_resp" : "rd_resp", 64'(rsp_resp), 64'(c.exp_resp));
            if (!c.we) begin
              check_val("rd_data", 64'(rsp_rdata), 64'(c.exp_rdata));
              last_rd_exp = c.exp_rdata;
            end else begin
              check_val("wr_rdata_hold", 64'(rsp_rdata), 64'(last_rd_exp));
            end
            if (c.exp_lat > 0) check_val("latency", 64'(cyc - a), 64'(c.exp_lat));
            $display("rsp req%0d %s addr=%h rdata=%h resp=%0d lat=%0d",
                     r, c.we ? "WR" : "RD", c.addr, rsp_rdata, rsp_resp, cyc - a);
          end
        end
      end
    end
    prev_rsp = rsp_valid;
    if (rst_n) begin
      if (prev_aw_stall) check_val("awvalid_held", 64'(axi.awvalid), 64'd1);
      if (prev_w_stall)  check_val("wvalid_held",  64'(axi.wvalid),  64'd1);
      if (prev_ar_stall) check_val("arvalid_held", 64'(axi.arvalid), 64'd1);
    end
    prev_aw_stall = rst_n && axi.awvalid && !axi.awready;
    prev_w_stall  = rst_n && axi.wvalid && !axi.wready;
    prev_ar_stall = rst_n && axi.arvalid && !axi.arready;
    if (!axi.awvalid && axi.wvalid) split_cycles++;
    if (rst_arm && axi.rready) begin
      rst_n   = 1'b0;
      rst_arm = 1'b0;
      rst_hit = 1'b1;
    end
  endtask

  task automatic drive();
    for (int r = 0; r < 2; r++) begin
      if (cq[r].size() > 0) begin
        req_valid[r] = 1'b1;
        req_we[r]    = cq[r][0].we;
        req_addr[r]  = cq[r][0].addr;
        req_wdata[r] = cq[r][0].wdata;
        req_wstrb[r] = 4'hF;
      end else begin
        req_valid[r] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic push(input int r, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic [1:0] exp_resp, input int exp_lat);
    cmd_t c;
    c.we = we; c.addr = addr; c.wdata = wdata;
    c.exp_rdata = exp_rdata; c.exp_resp = exp_resp; c.exp_lat = exp_lat;
    cq[r].push_back(c);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((cq[0].size() + cq[1].size() + pq[0].size() + pq[1].size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    check_val("drain_in_budget", 64'(cq[0].size() + cq[1].size() + pq[0].size() + pq[1].size()), 64'd0);
    tick();
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check_val({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check_val({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    check_val({tag, "_rsp_resp"},  64'(rsp_resp),  64'd0);
    check_val({tag, "_axi_vr"}, 64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 64'd0);
  endtask

  int exp_alt [9] = '{0, 1, 0, 1, 0, 1, 1, 1, 1};
  int rc;

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;

    // Reset held for 20 cycles; a command waits at the port during reset.
    repeat (15) tick();
    check_all_zero("rst");
    push(0, 1'b1, 32'h4, 32'h12345678, 32'h0, RESP_OKAY, 4);
    push(0, 1'b0, 32'h4, 32'h0, 32'h12345678, RESP_OKAY, 4);
    repeat (5) tick();
    check_val("rst_no_accept", 64'(req_ready), 64'd0);
    rst_n = 1'b1;
    wait_done(60);
    push(1, 1'b0, 32'h4, 32'h0, 32'h12345678, RESP_OKAY, 4);
    wait_done(30);

    // Simultaneous writes: req0 first, req1 five cycles later.
    glog.delete(); gcyc.delete();
    push(0, 1'b1, 32'h0, 32'hAAAA0000, 32'h0, RESP_OKAY, 4);
    push(1, 1'b1, 32'h8, 32'h5555FFFF, 32'h0, RESP_OKAY, 4);
    wait_done(60);
    check_val("sim_grant_cnt", 64'(glog.size()), 64'd2);
    check_val("sim_first", 64'(glog[0]), 64'd0);
    check_val("sim_second", 64'(glog[1]), 64'd1);
    check_val("accept_spacing", 64'(gcyc[1] - gcyc[0]), 64'd5);
    push(0, 1'b0, 32'h0, 32'h0, 32'hAAAA0000, RESP_OKAY, 4);
    push(1, 1'b0, 32'h8, 32'h0, 32'h5555FFFF, RESP_OKAY, 4);
    wait_done(60);

    // Fairness: req1 holds 6 reads, req0 issues 3.
    glog.delete(); gcyc.delete();
    push(0, 1'b0, 32'h0, 32'h0, 32'hAAAA0000, RESP_OKAY, 4);
    push(0, 1'b0, 32'h4, 32'h0, 32'h12345678, RESP_OKAY, 4);
    push(0, 1'b0, 32'h8, 32'h0, 32'h5555FFFF, RESP_OKAY, 4);
    push(1, 1'b0, 32'h0, 32'h0, 32'hAAAA0000, RESP_OKAY, 4);
    push(1, 1'b0, 32'h4, 32'h0, 32'h12345678, RESP_OKAY, 4);
    push(1, 1'b0, 32'h8, 32'h0, 32'h5555FFFF, RESP_OKAY, 4);
    push(1, 1'b0, 32'h0, 32'h0, 32'hAAAA0000, RESP_OKAY, 4);
    push(1, 1'b0, 32'h4, 32'h0, 32'h12345678, RESP_OKAY, 4);
    push(1, 1'b0, 32'h8, 32'h0, 32'h5555FFFF, RESP_OKAY, 4);
    wait_done(200);
    check_val("alt_grant_cnt", 64'(glog.size()), 64'd9);
    for (int i = 0; i < 9; i++) check_val($sformatf("alt_grant%0d", i), 64'(glog[i]), 64'(exp_alt[i]));

    // W stalled 3 cycles after AW handshake.
    w_delay = 3;
    split_cycles = 0;
    rc = rsp_cnt;
    push(0, 1'b1, 32'h10, 32'hCAFEF00D, 32'h0, RESP_OKAY, 7);
    wait_done(40);
    check_val("split_aw_w_cycles", 64'(split_cycles), 64'd3);
    check_val("stall_rsp_pulses", 64'(rsp_cnt - rc), 64'd1);
    w_delay = 0;
    push(0, 1'b0, 32'h10, 32'h0, 32'hCAFEF00D, RESP_OKAY, 4);
    wait_done(30);

    // Reset while waiting in RD_DATA.
    rc = rsp_cnt;
    rst_hit = 1'b0;
    rst_arm = 1'b1;
    push(0, 1'b0, 32'h4, 32'h0, 32'h12345678, RESP_OKAY, 4);
    for (int i = 0; i < 20 && !rst_hit; i++) tick();
    check_val("rst_in_rd_data_hit", 64'(rst_hit), 64'd1);
    rst_arm = 1'b0;
    check_all_zero("midrst");
    tick();
    tick();
    for (int r = 0; r < 2; r++) begin pq[r].delete(); pc[r].delete(); cq[r].delete(); end
    last_rd_exp = '0;
    rst_n = 1'b1;
    tick();
    check_val("midrst_no_rsp", 64'(rsp_cnt - rc), 64'd0);
    push(0, 1'b0, 32'h8, 32'h0, 32'h5555FFFF, RESP_OKAY, 4);
    wait_done(30);

    // Unmapped accesses return SLVERR to the issuing requester.
    push(1, 1'b0, 32'h100, 32'h0, 32'h0, RESP_SLVERR, 4);
    push(0, 1'b1, 32'h200, 32'h1, 32'h0, RESP_SLVERR, 4);
    wait_done(60);

    check_val("prot_tied", 64'({axi.awprot, axi.arprot}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
